// File: rtl/aes128_key_schedule_pkg.sv
// Shared AES-128 constants: widths, round constants, GF(2^8) helper.
// Imported by the key schedule and the cipher datapath.
package aes128_key_schedule_pkg;

   localparam int WORD_W  = 32;
   localparam int KEY_W   = 128;
   localparam int NROUNDS = 10;
   localparam int RIDX_W  = 4;

   // Entry i is the round constant used for the step after index i.
   localparam logic [NROUNDS-1:0][7:0] RCON_TAB = {
      8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
      8'h10, 8'h08, 8'h04, 8'h02, 8'h01
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// FIPS-197 forward S-box, purely combinational.
// Ports: a (8-bit input byte), d (8-bit substituted byte).
module aes_sbox_byte (
   input  logic [7:0] a,
   output logic [7:0] d
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,
      8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,
      8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,
      8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,
      8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,
      8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,
      8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,
      8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,
      8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,
      8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,
      8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,
      8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,
      8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,
      8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,
      8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,
      8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,
      8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   assign d = SBOX[a];

endmodule

// File: rtl/aes128_key_schedule.sv
// AES-128 on-the-fly key expansion: one round key per clock after kld.
// Ports: clk, rst (sync, active-low), kld, key[127:0]; wo_0..wo_3 round-key words.
module aes128_key_schedule
   import aes128_key_schedule_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              kld,
   input  logic [KEY_W-1:0]  key,
   output logic [WORD_W-1:0] wo_0,
   output logic [WORD_W-1:0] wo_1,
   output logic [WORD_W-1:0] wo_2,
   output logic [WORD_W-1:0] wo_3
);

   logic [WORD_W-1:0] w_q [4];
   logic [WORD_W-1:0] w_d [4];
   logic [RIDX_W-1:0] ridx_q;
   logic [RIDX_W-1:0] ridx_d;

   logic [WORD_W-1:0] rot;
   logic [WORD_W-1:0] subw;
   logic [WORD_W-1:0] t;
   logic [7:0]        rcon;

   // RotWord: byte order {b1,b2,b3,b0}; SubWord keeps byte positions.
   assign rot = {w_q[3][23:0], w_q[3][31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_sbox_byte u_sbox (
         .a (rot[i*8 +: 8]),
         .d (subw[i*8 +: 8])
      );
   end

   // Index saturates at NROUNDS, where the constant becomes zero.
   assign rcon = (ridx_q < RIDX_W'(NROUNDS)) ? RCON_TAB[ridx_q] : 8'h00;
   assign t    = subw ^ {rcon, 24'h0};

   always_comb begin
      w_d[0] = w_q[0] ^ t;
      w_d[1] = w_q[1] ^ w_d[0];
      w_d[2] = w_q[2] ^ w_d[1];
      w_d[3] = w_q[3] ^ w_d[2];
      ridx_d = (ridx_q == RIDX_W'(NROUNDS)) ? ridx_q : ridx_q + 1'b1;
      if (kld) begin
         w_d[0] = key[127:96];
         w_d[1] = key[95:64];
         w_d[2] = key[63:32];
         w_d[3] = key[31:0];
         ridx_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) w_q[i] <= '0;
         ridx_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
         ridx_q <= ridx_d;
      end
   end

   assign wo_0 = w_q[0];
   assign wo_1 = w_q[1];
   assign wo_2 = w_q[2];
   assign wo_3 = w_q[3];

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Self-checking bench for aes128_key_schedule and aes_sbox_byte.
// Vector table, GF(2^8)-derived reference model, scoreboard queue.
module tb_aes128_key_schedule;

   logic         clk;
   logic         rst;
   logic         kld;
   logic [127:0] key;
   logic [31:0]  wo_0, wo_1, wo_2, wo_3;
   logic [7:0]   sb_a;
   logic [7:0]   sb_d;

   int checks = 0;
   int errors = 0;

   aes128_key_schedule dut (
      .clk  (clk),
      .rst  (rst),
      .kld  (kld),
      .key  (key),
      .wo_0 (wo_0),
      .wo_1 (wo_1),
      .wo_2 (wo_2),
      .wo_3 (wo_3)
   );

   aes_sbox_byte u_sb (
      .a (sb_a),
      .d (sb_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference S-box built from the GF(2^8) inverse and affine map.
   logic [7:0] sb_ref [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d = {x, x};
      return d[15-n -: 8];
   endfunction

   function automatic void build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] aa = 8'(a);
         for (int b = 1; b < 256; b++)
            if (a != 0 && gmul(aa, 8'(b)) == 8'h01) inv = 8'(b);
         sb_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                   ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endfunction

   function automatic logic [7:0] rcon_of(input int idx);
      logic [7:0] r = 8'h01;
      if (idx >= 10) return 8'h00;
      for (int i = 0; i < idx; i++)
         r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
      return r;
   endfunction

   function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w3 = k[31:0];
      logic [31:0] t;
      logic [31:0] n0, n1, n2, n3;
      t  = {sb_ref[w3[23:16]], sb_ref[w3[15:8]],
            sb_ref[w3[7:0]], sb_ref[w3[31:24]]} ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   typedef struct {
      bit           chk;
      logic [127:0] exp;
   } sb_t;

   sb_t          q[$];
   logic [127:0] mw;
   int           midx;
   bit           loaded;

   // One clock: drive at negedge, predict, push; pop and compare after edge.
   task automatic cyc(input logic r, input logic k, input logic [127:0] kv);
      sb_t e;
      logic [127:0] got;
      @(negedge clk);
      rst = r;
      kld = k;
      key = kv;
      if (!r) begin
         mw = '0; midx = 0; loaded = 0; e.chk = 1;
      end else if (k) begin
         mw = kv; midx = 0; loaded = 1; e.chk = 1;
      end else begin
         mw = kexp(mw, rcon_of(midx));
         if (midx < 10) midx++;
         e.chk = loaded;
      end
      e.exp = mw;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      got = {wo_0, wo_1, wo_2, wo_3};
      if (e.chk) begin
         checks++;
         if (got !== e.exp) begin
            errors++;
            $display("FAIL model got %h want %h", got, e.exp);
         end
      end
   endtask

   task automatic chk(input string name, input logic [127:0] exp);
      logic [127:0] got = {wo_0, wo_1, wo_2, wo_3};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [127:0] key;
      int           n;
      logic [127:0] exp;
      string        name;
   } vec_t;

   localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ONES = '1;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{FIPS, 0, FIPS, "fips_r0"};
      vecs[1] = '{FIPS, 1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_r1"};
      vecs[2] = '{FIPS, 2, 128'hf2c295f27a96b9435935807a7359f67f, "fips_r2"};
      vecs[3] = '{FIPS, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_r10"};
      vecs[4] = '{128'h0, 0, 128'h0, "zero_r0"};
      vecs[5] = '{128'h0, 1, {4{32'h62636363}}, "zero_r1"};
      vecs[6] = '{128'h0, 2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, "zero_r2"};

      rst = 1'b0; kld = 1'b1; key = ONES; sb_a = 8'h00;
      mw = '0; midx = 0; loaded = 0;
      build_sbox();

      // Reset dominates kld.
      cyc(1'b0, 1'b1, ONES);
      cyc(1'b0, 1'b1, ONES);
      chk("reset", 128'h0);

      // S-box exhaustive plus known anchors.
      for (int i = 0; i < 256; i++) begin
         sb_a = 8'(i);
         #1;
         checks++;
         if (sb_d !== sb_ref[i]) begin
            errors++;
            $display("FAIL sbox[%02h] got %02h want %02h", i, sb_d, sb_ref[i]);
         end
      end
      begin
         logic [7:0] ins [4]  = '{8'h00, 8'h01, 8'h53, 8'hff};
         logic [7:0] outs [4] = '{8'h63, 8'h7c, 8'hed, 8'h16};
         for (int i = 0; i < 4; i++) begin
            sb_a = ins[i];
            #1;
            checks++;
            if (sb_d !== outs[i]) begin
               errors++;
               $display("FAIL sbox_anchor[%02h] got %02h want %02h", ins[i], sb_d, outs[i]);
            end
         end
      end

      for (int v = 0; v < 7; v++) begin
         cyc(1'b1, 1'b1, vecs[v].key);
         repeat (vecs[v].n) cyc(1'b1, 1'b0, '0);
         chk(vecs[v].name, vecs[v].exp);
      end

      // Reload mid-schedule restarts Rcon.
      cyc(1'b1, 1'b1, FIPS);
      repeat (4) cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 128'h0);
      chk("reload_r0", 128'h0);
      cyc(1'b1, 1'b0, '0);
      chk("reload_r1", {4{32'h62636363}});

      // Back-to-back kld holds the key.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, FIPS);
         chk("b2b_hold", FIPS);
      end
      cyc(1'b1, 1'b0, '0);
      chk("b2b_r1", 128'ha0fafe1788542cb123a339392a6c7605);

      // Past round 10 the constant is zero.
      cyc(1'b1, 1'b1, FIPS);
      repeat (13) cyc(1'b1, 1'b0, '0);

      for (int r = 0; r < 3; r++) begin
         cyc(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
         repeat (11) cyc(1'b1, 1'b0, '0);
      end

      // Reset mid-schedule.
      cyc(1'b1, 1'b1, FIPS);
      repeat (3) cyc(1'b1, 1'b0, '0);
      cyc(1'b0, 1'b1, ONES);
      chk("reset_mid", 128'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
